// File: rtl/axi4lite_master_sequencer.sv
// Single-outstanding AXI4-Lite master: takes one read/write command at a time,
// runs the AW/W/B or AR/R handshakes and returns one response pulse, with an optional timeout.
module axi4lite_master_sequencer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_timeout,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  input  logic [1:0]                m_bresp,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [ADDR_WIDTH-1:0]     m_araddr,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                m_rresp
);

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int TW    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RSP} state_e;

  state_e                    state_q, state_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic                      awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic                      bready_q, bready_d, rready_q, rready_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic                      rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;
  logic                      timed_out, abort;

  // Timer holds the number of cycles since accept, so it fires one cycle early to land RSP on the limit.
  assign timed_out = TO_EN && (timer_q >= TLAST);

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    bready_d      = bready_q;
    rready_d      = rready_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    abort         = 1'b0;

    if (TO_EN && state_q != IDLE && timer_q != TMAX) begin
      timer_d = timer_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          timer_d     = TW'(1);
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            state_d   = WADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      WADDR: begin
        if (timed_out) begin
          abort = 1'b1;
        end else begin
          awvalid_d = awvalid_q && !m_awready;
          wvalid_d  = wvalid_q && !m_wready;
          if (!awvalid_d && !wvalid_d) begin
            state_d  = WRESP;
            bready_d = 1'b1;
          end
        end
      end
      WRESP: begin
        // A response arriving on the timeout cycle still completes normally.
        if (m_bvalid) begin
          state_d       = RSP;
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = m_bresp;
          rsp_timeout_d = 1'b0;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end
      RADDR: begin
        if (timed_out) begin
          abort = 1'b1;
        end else if (m_arready) begin
          state_d   = RDATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RDATA: begin
        if (m_rvalid) begin
          state_d       = RSP;
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = m_rdata;
          rsp_resp_d    = m_rresp;
          rsp_timeout_d = 1'b0;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end
      RSP: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase

    if (abort) begin
      state_d       = RSP;
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      arvalid_d     = 1'b0;
      bready_d      = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = 2'b10;
      rsp_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      bready_q      <= bready_d;
      rready_q      <= rready_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;
  assign m_awvalid   = awvalid_q;
  assign m_awaddr    = addr_q;
  assign m_wvalid    = wvalid_q;
  assign m_wdata     = wdata_q;
  assign m_wstrb     = wstrb_q;
  assign m_bready    = bready_q;
  assign m_arvalid   = arvalid_q;
  assign m_araddr    = addr_q;
  assign m_rready    = rready_q;

  // A slave response while idle has nowhere to go; it is dropped here and flagged in simulation.
  a_no_stray_rsp: assert property (@(posedge aclk) disable iff (!aresetn)
    (state_q == IDLE) |-> !(m_bvalid || m_rvalid));

endmodule
